// File: rtl/reg_bank_pkg.sv
// Shared defaults, address-width helper and read-request type for the 2R1W register bank.
package reg_bank_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_CNT_DEF = 8;
    // Widest index the bank supports (REG_CNT up to 64); narrower addresses are zero-extended into it.
    localparam int ADDR_MAX_W  = 6;

    function automatic int addr_w(input int reg_cnt);
        return (reg_cnt > 2) ? $clog2(reg_cnt) : 1;
    endfunction

    typedef struct packed {
        logic                  en;
        logic [ADDR_MAX_W-1:0] addr;
    } rd_req_t;

endpackage

// File: rtl/reg_bank_if.sv
// Bus between the decode stage (master) and the 2R1W register bank (slave).
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = REG_CNT_DEF
);
    localparam int ADDR_W = addr_w(REG_CNT);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              lock_en;
    logic [ADDR_W-1:0] lock_addr;

    // Read handshake: a request (rd_en_x) is accepted at an edge where stall_x is low; rd_valid_x pulses
    // for one cycle after that edge with rd_data_x. While stalled the master holds rd_en_x and rd_addr_x.
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              stall_a;

    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              stall_b;

    logic [REG_CNT-1:0] busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, lock_en, lock_addr,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, stall_a,
        input  rd_data_b, rd_valid_b, stall_b,
        input  busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, lock_en, lock_addr,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, stall_a,
        output rd_data_b, rd_valid_b, stall_b,
        output busy_vec
    );

endinterface

// File: rtl/reg_bank_rd_port.sv
// One registered read port: stall/forward decision and the output data/valid register.
// Build option: define RB_WRITE_FORWARD_EN to forward same-cycle write data to the read.
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  rd_req_t               req_i,
    input  logic                  busy_i,
    input  logic [DATA_W-1:0]     word_i,
    input  logic                  wr_fire_i,
    input  logic [ADDR_MAX_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic                  stall_o
);

    logic              fwd_hit;
    logic              fire;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

`ifdef RB_WRITE_FORWARD_EN
    // wr_fire_i is already qualified, so dropped writes (r0, out of range) never forward.
    assign fwd_hit = req_i.en & wr_fire_i & (wr_addr_i == req_i.addr);
`else
    logic unused_fwd;
    assign unused_fwd = ^{wr_fire_i, wr_addr_i, wr_data_i, req_i.addr};
    assign fwd_hit    = 1'b0;
`endif

    assign stall_o   = req_i.en & busy_i & ~fwd_hit;
    assign fire      = req_i.en & ~stall_o;
    assign rd_data_d = fwd_hit ? wr_data_i : word_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= fire;
            if (fire) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_bank_2r1w.sv
// 2-read/1-write register bank with per-register busy scoreboard for multi-cycle producers.
// Build option: RB_WRITE_FORWARD_EN (handled inside reg_bank_rd_port).
module reg_bank_2r1w
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = REG_CNT_DEF,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    reg_bank_if.slave  bus
);

    localparam int ADDR_W = addr_w(REG_CNT);

    logic [DATA_W-1:0]  regs_q [REG_CNT];
    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_d;
    logic               wr_ok;
    logic               lock_ok;
    logic [DATA_W-1:0]  word_a;
    logic [DATA_W-1:0]  word_b;
    logic               busy_a;
    logic               busy_b;
    rd_req_t            req_a;
    rd_req_t            req_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < REG_CNT;
    endfunction

    // With ZERO_R0, r0 is never written or locked, so it stays 0 and never stalls on its own.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return in_range(a) && !(ZERO_R0 && (a == '0));
    endfunction

    assign wr_ok   = bus.wr_en & writable(bus.wr_addr);
    assign lock_ok = bus.lock_en & writable(bus.lock_addr);

    // Lock is applied after the write clear so a same-cycle lock leaves the register reserved.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < REG_CNT; i++) begin
            if (wr_ok && (int'(bus.wr_addr) == i)) begin
                busy_d[i] = 1'b0;
            end
            if (lock_ok && (int'(bus.lock_addr) == i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        word_a = '0;
        busy_a = 1'b0;
        if (in_range(bus.rd_addr_a)) begin
            word_a = regs_q[bus.rd_addr_a];
            busy_a = busy_q[bus.rd_addr_a];
        end
    end

    always_comb begin
        word_b = '0;
        busy_b = 1'b0;
        if (in_range(bus.rd_addr_b)) begin
            word_b = regs_q[bus.rd_addr_b];
            busy_b = busy_q[bus.rd_addr_b];
        end
    end

    assign req_a = {bus.rd_en_a, ADDR_MAX_W'(bus.rd_addr_a)};
    assign req_b = {bus.rd_en_b, ADDR_MAX_W'(bus.rd_addr_b)};

    reg_bank_rd_port #(.DATA_W(DATA_W)) u_port_a (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_a),
        .busy_i     (busy_a),
        .word_i     (word_a),
        .wr_fire_i  (wr_ok),
        .wr_addr_i  (ADDR_MAX_W'(bus.wr_addr)),
        .wr_data_i  (bus.wr_data),
        .rd_data_o  (bus.rd_data_a),
        .rd_valid_o (bus.rd_valid_a),
        .stall_o    (bus.stall_a)
    );

    reg_bank_rd_port #(.DATA_W(DATA_W)) u_port_b (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_b),
        .busy_i     (busy_b),
        .word_i     (word_b),
        .wr_fire_i  (wr_ok),
        .wr_addr_i  (ADDR_MAX_W'(bus.wr_addr)),
        .wr_data_i  (bus.wr_data),
        .rd_data_o  (bus.rd_data_b),
        .rd_valid_o (bus.rd_valid_b),
        .stall_o    (bus.stall_b)
    );

    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Directed bench: default 8x16 bank (dut0) and a 6-entry ZERO_R0 bank (dut1).
module tb_reg_bank_2r1w;

`ifdef RB_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    reg_bank_if #(.DATA_W(16), .REG_CNT(8)) bus0 ();
    reg_bank_if #(.DATA_W(16), .REG_CNT(6)) bus1 ();

    reg_bank_2r1w #(.DATA_W(16), .REG_CNT(8), .ZERO_R0(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    reg_bank_2r1w #(.DATA_W(16), .REG_CNT(6), .ZERO_R0(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.wr_en = 0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus0.lock_en = 0; bus0.lock_addr = '0;
        bus0.rd_en_a = 0; bus0.rd_addr_a = '0;
        bus0.rd_en_b = 0; bus0.rd_addr_b = '0;
    endtask

    task automatic idle1();
        bus1.wr_en = 0; bus1.wr_addr = '0; bus1.wr_data = '0;
        bus1.lock_en = 0; bus1.lock_addr = '0;
        bus1.rd_en_a = 0; bus1.rd_addr_a = '0;
        bus1.rd_en_b = 0; bus1.rd_addr_b = '0;
    endtask

    initial begin
        reset0 = 1; reset1 = 1;
        idle0(); idle1();
        step(); step();
        check("rst_busy", bus0.busy_vec, 32'h0);
        check("rst_valid_a", bus0.rd_valid_a, 32'h0);
        check("rst_data_a", bus0.rd_data_a, 32'h0);
        check("rst_data_b", bus0.rd_data_b, 32'h0);
        reset0 = 0;

        for (int i = 0; i < 8; i++) begin
            bus0.rd_en_a = 1; bus0.rd_addr_a = 3'(i);
            bus0.rd_en_b = 1; bus0.rd_addr_b = 3'(7 - i);
            step();
            check($sformatf("rst_rd_a%0d", i), {bus0.rd_valid_a, bus0.rd_data_a}, 32'h10000);
            check($sformatf("rst_rd_b%0d", 7 - i), {bus0.rd_valid_b, bus0.rd_data_b}, 32'h10000);
        end
        bus0.rd_en_a = 0; bus0.rd_en_b = 0;
        step();
        check("valid_a_pulse_end", bus0.rd_valid_a, 32'h0);
        check("valid_b_pulse_end", bus0.rd_valid_b, 32'h0);

        // write r3 then read it on both ports
        bus0.wr_en = 1; bus0.wr_addr = 3; bus0.wr_data = 16'hBEEF;
        step();
        bus0.wr_en = 0;
        bus0.rd_en_a = 1; bus0.rd_addr_a = 3; bus0.rd_en_b = 1; bus0.rd_addr_b = 3;
        step();
        check("r3_a", {bus0.rd_valid_a, bus0.rd_data_a}, 32'h1BEEF);
        check("r3_b", {bus0.rd_valid_b, bus0.rd_data_b}, 32'h1BEEF);
        bus0.rd_en_a = 0; bus0.rd_en_b = 0;

        // read-during-write on r5
        bus0.wr_en = 1; bus0.wr_addr = 5; bus0.wr_data = 16'h0042;
        step();
        bus0.wr_data = 16'h1234;
        bus0.rd_en_a = 1; bus0.rd_addr_a = 5;
        step();
        bus0.wr_en = 0;
        check("rdw_r5", bus0.rd_data_a, FWD ? 32'h1234 : 32'h0042);
        step();
        check("r5_after", {bus0.rd_valid_a, bus0.rd_data_a}, 32'h11234);
        check("b_hold", {bus0.rd_valid_b, bus0.rd_data_b}, 32'h0BEEF);
        bus0.rd_en_a = 0;

        // lock r2, read stalls, producer write releases it
        bus0.lock_en = 1; bus0.lock_addr = 2;
        step();
        bus0.lock_en = 0;
        check("lock_busy", bus0.busy_vec, 32'h04);
        bus0.rd_en_a = 1; bus0.rd_addr_a = 2;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("lock_stall%0d", k), bus0.stall_a, 32'h1);
            step();
            check($sformatf("lock_valid%0d", k), bus0.rd_valid_a, 32'h0);
            check($sformatf("lock_hold%0d", k), bus0.rd_data_a, 32'h1234);
        end
        bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 16'h00AA;
        #1 check("prod_wr_stall", bus0.stall_a, FWD ? 32'h0 : 32'h1);
        step();
        bus0.wr_en = 0;
        check("prod_busy_clr", bus0.busy_vec, 32'h0);
        check("prod_valid", bus0.rd_valid_a, {31'h0, FWD});
        #1 check("prod_stall_off", bus0.stall_a, 32'h0);
        step();
        check("prod_data", {bus0.rd_valid_a, bus0.rd_data_a}, 32'h100AA);
        bus0.rd_en_a = 0;

        // same-cycle lock and write on r4
        bus0.lock_en = 1; bus0.lock_addr = 4;
        bus0.wr_en = 1; bus0.wr_addr = 4; bus0.wr_data = 16'h5555;
        step();
        bus0.lock_en = 0; bus0.wr_en = 0;
        check("lockwr_busy", bus0.busy_vec, 32'h10);
        bus0.rd_en_a = 1; bus0.rd_addr_a = 4; bus0.rd_en_b = 1; bus0.rd_addr_b = 4;
        #1 check("lockwr_stall_a", bus0.stall_a, 32'h1);
        check("lockwr_stall_b", bus0.stall_b, 32'h1);
        step();
        check("lockwr_valid", bus0.rd_valid_a, 32'h0);
        bus0.wr_en = 1; bus0.wr_addr = 4; bus0.wr_data = 16'h0777;
        step();
        bus0.wr_en = 0;
        step();
        check("r4_a", {bus0.rd_valid_a, bus0.rd_data_a}, 32'h10777);
        check("r4_b", {bus0.rd_valid_b, bus0.rd_data_b}, 32'h10777);
        idle0();

        // ZERO_R0, REG_CNT=6 instance
        reset1 = 0;
        bus1.wr_en = 1; bus1.wr_addr = 1; bus1.wr_data = 16'h1111;
        step();
        bus1.wr_addr = 0; bus1.wr_data = 16'hFFFF;
        bus1.lock_en = 1; bus1.lock_addr = 0;
        step();
        bus1.wr_en = 0; bus1.lock_en = 0;
        check("z_r0_lock", bus1.busy_vec, 32'h0);
        bus1.rd_en_a = 1; bus1.rd_addr_a = 0; bus1.rd_en_b = 1; bus1.rd_addr_b = 1;
        #1 check("z_r0_stall", bus1.stall_a, 32'h0);
        step();
        check("z_r0_rd", {bus1.rd_valid_a, bus1.rd_data_a}, 32'h10000);
        check("z_r1_rd", {bus1.rd_valid_b, bus1.rd_data_b}, 32'h11111);

        // out-of-range write/lock ignored, reads return 0 with valid
        bus1.rd_en_b = 0;
        bus1.wr_en = 1; bus1.wr_addr = 7; bus1.wr_data = 16'hABCD;
        bus1.lock_en = 1; bus1.lock_addr = 7;
        bus1.rd_addr_a = 1;
        step();
        bus1.wr_en = 0; bus1.lock_en = 0;
        check("oor_busy", bus1.busy_vec, 32'h0);
        check("a_r1", bus1.rd_data_a, 32'h1111);
        bus1.rd_addr_a = 7; bus1.rd_en_b = 1; bus1.rd_addr_b = 6;
        #1 check("oor_stall_a", bus1.stall_a, 32'h0);
        check("oor_stall_b", bus1.stall_b, 32'h0);
        step();
        check("oor_rd_a", {bus1.rd_valid_a, bus1.rd_data_a}, 32'h10000);
        check("oor_rd_b", {bus1.rd_valid_b, bus1.rd_data_b}, 32'h10000);
        bus1.rd_en_b = 0;

        // reset during a stall
        bus1.rd_addr_a = 1;
        bus1.lock_en = 1; bus1.lock_addr = 3;
        step();
        bus1.lock_en = 0;
        check("mid_pre", bus1.rd_data_a, 32'h1111);
        check("mid_busy", bus1.busy_vec, 32'h08);
        bus1.rd_addr_a = 3;
        #1 check("mid_stall", bus1.stall_a, 32'h1);
        step();
        check("mid_valid", bus1.rd_valid_a, 32'h0);
        reset1 = 1;
        step();
        check("mid_rst_busy", bus1.busy_vec, 32'h0);
        check("mid_rst_valid", bus1.rd_valid_a, 32'h0);
        check("mid_rst_data", bus1.rd_data_a, 32'h0);
        check("mid_rst_stall", bus1.stall_a, 32'h0);
        reset1 = 0;
        bus1.rd_en_a = 0;
        step();
        check("mid_after_valid", bus1.rd_valid_a, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_2r1w.md
Name: reg_bank_2r1w

Overview:
Parametrised successor to the 8x16 general-purpose register bank. Provides one synchronous write port and two registered read ports, so the ALU stage can fetch both operands in one cycle. Adds a per-register busy scoreboard so that multi-cycle producers (load, multiply) can reserve a destination register, and reads of a reserved register stall until it is written. Sits between the decode stage and the operand latches of the datapath.

Parameters:
DATA_W, 16, width of each register in bits
REG_CNT, 8, number of registers (2..64; need not be a power of 2)
ADDR_W, $clog2(REG_CNT), derived localparam; register address width
ZERO_R0, 0, when 1: register 0 always reads 0, and writes to it are dropped

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
lock_en  in  1  mark lock_addr busy (reserve for a pending producer)
lock_addr  in  ADDR_W  register to reserve
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read index, port A
rd_data_a  out  DATA_W  registered read data, port A
rd_valid_a  out  1  one-cycle pulse: rd_data_a was updated this cycle
stall_a  out  1  combinational: port A request cannot be served this cycle
rd_en_b / rd_addr_b / rd_data_b / rd_valid_b / stall_b  same as port A, for port B
busy_vec  out  REG_CNT  current scoreboard (bit i = register i reserved)

Behaviour:
- Reset (reset=1 at an edge): all registers, busy_vec, rd_data_*, and rd_valid_* go to 0. Reset overrides any simultaneous write, lock, or read. An in-flight read is dropped: rd_valid stays 0 in the following cycle.
- Write: at the edge with wr_en=1, reg[wr_addr] <= wr_data, and busy[wr_addr] is cleared.
- Lock: at the edge with lock_en=1, busy[lock_addr] is set. Lock and write to the same address in the same cycle: the register takes wr_data and busy ends at 1 (lock wins; a new producer is queued).
- Out-of-range index (>= REG_CNT): writes and locks are ignored; reads return 0 with rd_valid=1 and no stall.
- ZERO_R0=1: writes to and locks on address 0 are ignored; reads of address 0 return 0 and never stall.
- Read latency is 1 cycle. If rd_en_x=1 and stall_x=0 at edge N, then after edge N rd_data_x holds the value and rd_valid_x=1 for exactly one cycle.
- stall_x = rd_en_x & busy[rd_addr_x] & ~forward_hit_x, where forward_hit_x is defined only under the optional feature and is otherwise 0.
- While stalled: rd_data_x holds its previous value and rd_valid_x=0. The requester keeps rd_en and rd_addr stable; the read completes in the first cycle busy is clear (or a forward hit occurs).
- When no read is issued, rd_data_x holds its previous value.
- Ports A and B are fully independent; both may read the same address in the same cycle.
- Read-during-write to the same address without the optional feature returns the OLD value.

Optional Feature:
RB_WRITE_FORWARD_EN
- Defined: if wr_en=1 and wr_addr==rd_addr_x in the same cycle, port x returns wr_data (forward_hit_x=1). This also un-stalls a read of a busy register whose producer writes that cycle.
- Undefined: old value is returned; a busy register stalls until the cycle after the write.

Decomposition:
- Package reg_bank_pkg: DATA_W and REG_CNT defaults, ADDR_W derivation function, and a rd_req_t struct {en, addr}.
- One natural sub-module, reg_bank_rd_port: handles the stall/forward decision and the output register for a single port. It is instantiated twice; the storage array and scoreboard stay in the top module.

Test Plan:
- Reset, then read r0..r7 on both ports -> every rd_data = 0x0000, rd_valid pulses one cycle after each request, busy_vec = 0.
- Write r3=0xBEEF, next cycle read A=r3, B=r3 -> both ports return 0xBEEF one cycle after the request.
- Same-cycle write r5=0x1234 and read A=r5 (r5 previously 0x0042) -> 0x0042 without RB_WRITE_FORWARD_EN; 0x1234 with it.
- Lock r2; read A=r2 for 3 cycles -> stall_a=1 and rd_valid_a=0. Then write r2=0x00AA -> busy[2] clears and the read completes with 0x00AA (same cycle with forwarding, one cycle later without).
- Same-cycle lock r4 and write r4=0x5555 -> reg[4]=0x5555 and busy[4]=1; subsequent read of r4 stalls.
- ZERO_R0=1, REG_CNT=6: write r0=0xFFFF, read r0 -> 0. Read address 7 -> 0, valid, no stall. Reset asserted mid-stall -> stall clears (busy=0) and rd_valid stays 0 in the following cycle.
